// File: rtl/flex_countdown_timer_if.sv
// Interface bundling the control and status signals of flex_countdown_timer.
//   master : drives clear/load/load_val/auto_reload/count_enable, observes status
//   slave  : the timer itself; observes controls, drives count_out/expire_flag/busy
// clk and rst are kept as plain ports on the timer and are not part of this bundle.
interface flex_countdown_timer_if #(
   parameter int unsigned NUM_CNT_BITS = 4
);
   logic                    clear;
   logic                    load;
   logic [NUM_CNT_BITS-1:0] load_val;
   logic                    auto_reload;
   logic                    count_enable;
   logic [NUM_CNT_BITS-1:0] count_out;
   logic                    expire_flag;
   logic                    busy;

   modport master (
      output clear, load, load_val, auto_reload, count_enable,
      input  count_out, expire_flag, busy
   );

   modport slave (
      input  clear, load, load_val, auto_reload, count_enable,
      output count_out, expire_flag, busy
   );
endinterface

// File: rtl/flex_countdown_timer.sv
// Loadable down-counter with one-shot or periodic expiry.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave modport of flex_countdown_timer_if
//            clear        synchronous abort to IDLE, count 0
//            load         capture load_val (0 = return to IDLE) and start counting
//            load_val     start/reload value
//            auto_reload  1 = periodic, 0 = one-shot (sampled at expiry only)
//            count_enable decrement strobe, honoured only while running
//            count_out    registered current count
//            expire_flag  registered one-cycle pulse on expiry
//            busy         high while running
// Priority per edge: rst > clear > load > count_enable.
module flex_countdown_timer #(
   parameter int unsigned NUM_CNT_BITS = 4
) (
   input logic                   clk,
   input logic                   rst,
   flex_countdown_timer_if.slave bus
);

   localparam logic [NUM_CNT_BITS-1:0] CntZero = '0;
   localparam logic [NUM_CNT_BITS-1:0] CntOne  = NUM_CNT_BITS'(1);

   typedef enum logic {StIdle, StRun} state_e;

   state_e                  state_q,  state_d;
   logic [NUM_CNT_BITS-1:0] count_q,  count_d;
   logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
   logic                    expire_q, expire_d;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      expire_d = 1'b0;

      if (bus.clear) begin
         state_d = StIdle;
         count_d = CntZero;
      end else if (bus.load) begin
         // A zero load acts as a stop; the reload value is kept.
         if (bus.load_val != CntZero) begin
            count_d  = bus.load_val;
            reload_d = bus.load_val;
            state_d  = StRun;
         end else begin
            count_d = CntZero;
            state_d = StIdle;
         end
      end else if ((state_q == StRun) && bus.count_enable) begin
         if (count_q > CntOne) begin
            count_d = count_q - CntOne;
         end else if (count_q == CntOne) begin
            expire_d = 1'b1;
            if (bus.auto_reload) begin
               count_d = reload_q;
            end else begin
               count_d = CntZero;
               state_d = StIdle;
            end
         end else begin
            // Zero while running is unreachable; fall back to IDLE rather than wrap.
            state_d = StIdle;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         count_q  <= CntZero;
         reload_q <= CntZero;
         expire_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         expire_q <= expire_d;
      end
   end

   assign bus.count_out   = count_q;
   assign bus.expire_flag = expire_q;
   assign bus.busy        = (state_q == StRun);

endmodule

// File: tb/tb_flex_countdown_timer.sv
// Directed bench for flex_countdown_timer: a 4-bit instance for the functional scenarios and an
// 8-bit instance for the full-range countdown. Each step drives inputs, queues the expected
// post-edge outputs, and compares them after the edge.
module tb_flex_countdown_timer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   flex_countdown_timer_if #(.NUM_CNT_BITS(4)) bus4 ();
   flex_countdown_timer_if #(.NUM_CNT_BITS(8)) bus8 ();

   flex_countdown_timer #(.NUM_CNT_BITS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
   flex_countdown_timer #(.NUM_CNT_BITS(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

   typedef struct {
      string      tag;
      bit         which;
      logic [7:0] cnt;
      logic       flg;
      logic       bsy;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   // which: 0 = 4-bit instance, 1 = 8-bit instance. The other instance sees idle inputs.
   task automatic step(input bit which, input bit clr, input bit ld, input logic [7:0] lv,
                       input bit ar, input bit en, input logic [7:0] ec, input logic ef,
                       input logic eb, input string tag);
      exp_t       e;
      logic [7:0] oc;
      logic       of;
      logic       ob;
      bus4.clear        = which ? 1'b0 : clr;
      bus4.load         = which ? 1'b0 : ld;
      bus4.load_val     = which ? 4'd0 : lv[3:0];
      bus4.auto_reload  = which ? 1'b0 : ar;
      bus4.count_enable = which ? 1'b0 : en;
      bus8.clear        = which ? clr : 1'b0;
      bus8.load         = which ? ld : 1'b0;
      bus8.load_val     = which ? lv : 8'd0;
      bus8.auto_reload  = which ? ar : 1'b0;
      bus8.count_enable = which ? en : 1'b0;
      sb.push_back('{tag: tag, which: which, cnt: ec, flg: ef, bsy: eb});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (e.which) begin
         oc = bus8.count_out;
         of = bus8.expire_flag;
         ob = bus8.busy;
      end else begin
         oc = {4'd0, bus4.count_out};
         of = bus4.expire_flag;
         ob = bus4.busy;
      end
      checks++;
      assert (oc === e.cnt) else begin
         failures++;
         $error("FAIL %s count_out got=%0d exp=%0d", e.tag, oc, e.cnt);
      end
      checks++;
      assert (of === e.flg) else begin
         failures++;
         $error("FAIL %s expire_flag got=%b exp=%b", e.tag, of, e.flg);
      end
      checks++;
      assert (ob === e.bsy) else begin
         failures++;
         $error("FAIL %s busy got=%b exp=%b", e.tag, ob, e.bsy);
      end
   endtask

   initial begin
      // 1. reset for two cycles, then enables in IDLE are ignored
      rst = 1'b1;
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, "rst0");
      step(0, 0, 0, 0, 0, 1, 0, 0, 0, "rst1");
      rst = 1'b0;
      step(0, 0, 0, 0, 0, 1, 0, 0, 0, "idle_en0");
      step(0, 0, 0, 0, 0, 1, 0, 0, 0, "idle_en1");

      // 2. one-shot load 5
      step(0, 0, 1, 5, 0, 0, 5, 0, 1, "os_load");
      step(0, 0, 0, 0, 0, 1, 4, 0, 1, "os_4");
      step(0, 0, 0, 0, 0, 1, 3, 0, 1, "os_3");
      step(0, 0, 0, 0, 0, 1, 2, 0, 1, "os_2");
      step(0, 0, 0, 0, 0, 1, 1, 0, 1, "os_1");
      step(0, 0, 0, 0, 0, 1, 0, 1, 0, "os_expire");
      step(0, 0, 0, 0, 0, 1, 0, 0, 0, "os_after");

      // 3. periodic load 3, nine enables -> three pulses
      step(0, 0, 1, 3, 1, 0, 3, 0, 1, "per_load");
      for (int p = 0; p < 3; p++) begin
         step(0, 0, 0, 0, 1, 1, 2, 0, 1, "per_2");
         step(0, 0, 0, 0, 1, 1, 1, 0, 1, "per_1");
         step(0, 0, 0, 0, 1, 1, 3, 1, 1, "per_reload");
      end
      step(0, 0, 0, 0, 1, 0, 3, 0, 1, "per_hold");

      // 4. pause then clear
      step(0, 0, 1, 4, 0, 0, 4, 0, 1, "pa_load");
      step(0, 0, 0, 0, 0, 1, 3, 0, 1, "pa_3");
      step(0, 0, 0, 0, 0, 1, 2, 0, 1, "pa_2");
      for (int h = 0; h < 3; h++) step(0, 0, 0, 0, 0, 0, 2, 0, 1, "pa_hold");
      step(0, 1, 0, 0, 0, 1, 0, 0, 0, "pa_clear");
      step(0, 0, 0, 0, 0, 1, 0, 0, 0, "pa_after");

      // 5. load colliding with expiry, then zero load
      step(0, 0, 1, 2, 0, 0, 2, 0, 1, "col_load");
      step(0, 0, 0, 0, 0, 1, 1, 0, 1, "col_1");
      step(0, 0, 1, 7, 0, 1, 7, 0, 1, "col_reload7");
      step(0, 0, 0, 0, 0, 1, 6, 0, 1, "col_6");
      step(0, 0, 1, 0, 0, 1, 0, 0, 0, "col_zero");

      // auto_reload sampled only on the expiry edge
      step(0, 0, 1, 2, 0, 0, 2, 0, 1, "ar_load");
      step(0, 0, 0, 0, 1, 1, 1, 0, 1, "ar_1");
      step(0, 0, 0, 0, 1, 1, 2, 1, 1, "ar_reload");
      step(0, 0, 0, 0, 0, 1, 1, 0, 1, "ar_1b");
      step(0, 0, 0, 0, 0, 1, 0, 1, 0, "ar_stop");

      // back-to-back pulses with period 1
      step(0, 0, 1, 1, 1, 0, 1, 0, 1, "b2b_load");
      step(0, 0, 0, 0, 1, 1, 1, 1, 1, "b2b_p0");
      step(0, 0, 0, 0, 1, 1, 1, 1, 1, "b2b_p1");

      // reset mid-run aborts without a pulse
      step(0, 0, 1, 3, 0, 0, 3, 0, 1, "rr_load");
      step(0, 0, 0, 0, 0, 1, 2, 0, 1, "rr_2");
      rst = 1'b1;
      step(0, 0, 0, 0, 0, 1, 0, 0, 0, "rr_rst");
      rst = 1'b0;

      // 6. 8-bit instance: full-range countdown, no wrap
      step(1, 0, 1, 8'd255, 0, 0, 8'd255, 0, 1, "w8_load");
      for (int i = 1; i <= 255; i++) begin
         step(1, 0, 0, 0, 0, 1, 8'(255 - i), (i == 255), (i != 255), "w8_cnt");
      end
      step(1, 0, 0, 0, 0, 1, 0, 0, 0, "w8_nowrap");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
